// File: rtl/meteor_pkg.sv
// Shared meteor constants, per-slot state record and spawn column helper.
// The spawn column is folded so a 16-pixel sprite never starts past the right edge.
package meteor_pkg;

  localparam int N_SLOTS      = 4;
  localparam int SPAWN_PERIOD = 32;
  localparam int SPEED        = 2;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int SPR_SIZE     = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] sprite;
  } slot_t;

  function automatic logic [9:0] spawn_x(input logic [9:0] r);
    return (r >= 10'(SCREEN_W - SPR_SIZE)) ? r - 10'd512 : r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11), steps every clock.
// Synchronous reset loads SEED; no enable, never stalls.
module lfsr16
  import meteor_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic fb;

  assign fb = state[0] ^ state[2] ^ state[3] ^ state[5];

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= {fb, state[15:1]};
  end

endmodule

// File: rtl/meteor_ctrl.sv
// Meteor slot manager (spawn/fall/kill) plus 2-cycle pixel hit pipeline into an external sprite ROM.
// One pixel per cycle, no stalls; METEOR_COIN_EN enables sprite 3 (coin) and pix_coin.
module meteor_ctrl
  import meteor_pkg::*;
#(
  parameter int N_SLOTS      = meteor_pkg::N_SLOTS,
  parameter int SPAWN_PERIOD = meteor_pkg::SPAWN_PERIOD,
  parameter int SPEED        = meteor_pkg::SPEED
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               px_valid,
  input  logic [9:0]         px_x,
  input  logic [9:0]         px_y,
  input  logic               kill_valid,
  input  logic [1:0]         kill_slot,
  output logic [3:0]         rom_y,
  output logic [1:0]         rom_sprite,
  input  logic [15:0]        rom_bits,
  output logic               pix_on,
  output logic               pix_coin,
  output logic [1:0]         pix_slot,
  output logic [N_SLOTS-1:0] active
);

  localparam int            CW     = $clog2(SPAWN_PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SPAWN_PERIOD - 1);

  slot_t              slots     [N_SLOTS];
  slot_t              slots_nxt [N_SLOTS];
  logic [CW-1:0]      spawn_cnt;
  logic [CW-1:0]      spawn_cnt_nxt;
  logic               spawn_due;
  logic [N_SLOTS-1:0] spawn_sel;
  logic [1:0]         new_sprite;
  logic [15:0]        lfsr;
  logic               lfsr_unused;

  logic               hit;
  logic [1:0]         hit_slot;
  logic [3:0]         hit_dx;
  logic [3:0]         hit_dy;
  logic [1:0]         hit_spr;
  logic               hit_q;
  logic [3:0]         col_q;
  logic [1:0]         slot_q;
  logic               lit;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:12];

  always_comb begin
    new_sprite = lfsr[11:10];
`ifndef METEOR_COIN_EN
    if (new_sprite == 2'd3) new_sprite = 2'd0;
`endif
  end

  // Target is picked from the start-of-cycle mask, so a same-cycle kill or exit never redirects it.
  always_comb begin
    logic taken;
    taken     = 1'b0;
    spawn_sel = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      spawn_sel[i] = !slots[i].active && !taken;
      taken        = taken | !slots[i].active;
    end
  end

  assign spawn_due     = frame_tick && (spawn_cnt == '0);
  assign spawn_cnt_nxt = !frame_tick ? spawn_cnt :
                         spawn_due   ? RELOAD    : spawn_cnt - CW'(1);

  always_comb begin
    logic [10:0] ny;
    ny = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      slots_nxt[i] = slots[i];
      ny = {1'b0, slots[i].y} + 11'(SPEED);
      if (frame_tick && slots[i].active) begin
        slots_nxt[i].y = ny[9:0];
        if (ny >= 11'(SCREEN_H)) slots_nxt[i].active = 1'b0;
      end
      if (kill_valid && (kill_slot == 2'(i))) slots_nxt[i].active = 1'b0;
      if (spawn_due && spawn_sel[i])
        slots_nxt[i] = '{active: 1'b1, x: spawn_x(lfsr[9:0]), y: 10'd0, sprite: new_sprite};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= '0;
      spawn_cnt <= RELOAD;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) slots[i] <= slots_nxt[i];
      spawn_cnt <= spawn_cnt_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) active[i] = slots[i].active;
  end

  // Scan high to low so the lowest matching index is the one left standing.
  always_comb begin
    logic [9:0] dx;
    logic [9:0] dy;
    dx       = '0;
    dy       = '0;
    hit      = 1'b0;
    hit_slot = '0;
    hit_dx   = '0;
    hit_dy   = '0;
    hit_spr  = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      dx = px_x - slots[i].x;
      dy = px_y - slots[i].y;
      if (px_valid && slots[i].active && (dx < 10'(SPR_SIZE)) && (dy < 10'(SPR_SIZE))) begin
        hit      = 1'b1;
        hit_slot = 2'(i);
        hit_dx   = dx[3:0];
        hit_dy   = dy[3:0];
        hit_spr  = slots[i].sprite;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q      <= 1'b0;
      col_q      <= '0;
      slot_q     <= '0;
      rom_y      <= '0;
      rom_sprite <= '0;
    end else begin
      hit_q      <= hit;
      col_q      <= hit_dx;
      slot_q     <= hit_slot;
      rom_y      <= hit_dy;
      rom_sprite <= hit_spr;
    end
  end

  assign lit = hit_q & rom_bits[4'd15 - col_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_on   <= 1'b0;
      pix_slot <= '0;
    end else begin
      pix_on   <= lit;
      pix_slot <= slot_q;
    end
  end

`ifdef METEOR_COIN_EN
  always_ff @(posedge clk) begin
    if (reset) pix_coin <= 1'b0;
    else       pix_coin <= lit & (rom_sprite == 2'd3);
  end
`else
  assign pix_coin = 1'b0;
`endif

endmodule

// File: tb/tb_meteor_ctrl.sv
// Scoreboarded bench for meteor_ctrl: slot model drives expectations, monitor pops on 2-cycle-delayed pixels.
module tb_meteor_ctrl;

  logic        clk = 1'b0;
  logic        reset, frame_tick, px_valid, kill_valid;
  logic [9:0]  px_x, px_y;
  logic [1:0]  kill_slot, rom_sprite, pix_slot;
  logic [3:0]  rom_y, active;
  logic [15:0] rom_bits;
  logic        pix_on, pix_coin;

  always #5 clk = ~clk;

  meteor_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .px_valid   (px_valid),
    .px_x       (px_x),
    .px_y       (px_y),
    .kill_valid (kill_valid),
    .kill_slot  (kill_slot),
    .rom_y      (rom_y),
    .rom_sprite (rom_sprite),
    .rom_bits   (rom_bits),
    .pix_on     (pix_on),
    .pix_coin   (pix_coin),
    .pix_slot   (pix_slot),
    .active     (active)
  );

  // Bench sprite ROM: each row lights one diagonal column plus the rightmost column.
  function automatic logic [15:0] rom_fn(input logic [1:0] s, input logic [3:0] r);
    logic [3:0] c;
    c = r + 4'd1 + {2'b00, s};
    return (16'h8000 >> c) | 16'h0001;
  endfunction

  always_comb rom_bits = rom_fn(rom_sprite, rom_y);

  typedef struct {
    bit         act;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] spr;
  } mslot_t;

  typedef struct {
    bit         hit;
    bit         on;
    bit         coin;
    logic [1:0] slot;
  } exp_t;

  mslot_t      ms [4];
  int          mcnt;
  logic [15:0] m_lfsr;
  exp_t        sbq [$];
  int          checks = 0;
  int          failures = 0;
  bit          v1 = 1'b0, v2 = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  always @(posedge clk) m_lfsr <= reset ? 16'hACE1 : lfsr_step(m_lfsr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mmask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i] = ms[i].act;
    return m;
  endfunction

  function automatic exp_t exp_pixel(input logic [9:0] x, input logic [9:0] y);
    exp_t       e;
    logic [9:0] dx, dy;
    logic [15:0] row;
    e = '{hit: 1'b0, on: 1'b0, coin: 1'b0, slot: 2'd0};
    for (int i = 0; i < 4; i++) begin
      dx = x - ms[i].x;
      dy = y - ms[i].y;
      if (!e.hit && ms[i].act && dx < 10'd16 && dy < 10'd16) begin
        e.hit  = 1'b1;
        e.slot = 2'(i);
        row    = rom_fn(ms[i].spr, dy[3:0]);
        e.on   = row[4'd15 - dx[3:0]];
        e.coin = e.on && (ms[i].spr == 2'd3);
      end
    end
    return e;
  endfunction

  task automatic model_tick(input bit kv, input logic [1:0] ks);
    int         tgt;
    bit         due;
    logic [1:0] s;
    tgt = -1;
    for (int i = 0; i < 4; i++) if (!ms[i].act && tgt < 0) tgt = i;
    due  = (mcnt == 0);
    mcnt = due ? 31 : mcnt - 1;
    for (int i = 0; i < 4; i++) begin
      if (ms[i].act) begin
        ms[i].y = ms[i].y + 10'd2;
        if (ms[i].y >= 10'd480) ms[i].act = 1'b0;
      end
      if (kv && ks == 2'(i)) ms[i].act = 1'b0;
    end
    if (due && tgt >= 0) begin
      s = m_lfsr[11:10];
`ifndef METEOR_COIN_EN
      if (s == 2'd3) s = 2'd0;
`endif
      ms[tgt].act = 1'b1;
      ms[tgt].x   = (m_lfsr[9:0] >= 10'd624) ? m_lfsr[9:0] - 10'd512 : m_lfsr[9:0];
      ms[tgt].y   = 10'd0;
      ms[tgt].spr = s;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ms[i] = '{act: 1'b0, x: 10'd0, y: 10'd0, spr: 2'd0};
    mcnt = 31;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic tick(input bit kv, input logic [1:0] ks);
    @(negedge clk);
    frame_tick = 1'b1;
    kill_valid = kv;
    kill_slot  = ks;
    model_tick(kv, ks);
    @(negedge clk);
    frame_tick = 1'b0;
    kill_valid = 1'b0;
    chk("active_after_tick", {28'd0, active}, mmask());
  endtask

  task automatic kill_only(input logic [1:0] ks);
    @(negedge clk);
    kill_valid = 1'b1;
    kill_slot  = ks;
    ms[ks].act = 1'b0;
    @(negedge clk);
    kill_valid = 1'b0;
    chk("active_after_kill", {28'd0, active}, mmask());
  endtask

  task automatic px(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    px_valid = 1'b1;
    px_x     = x;
    px_y     = y;
    sbq.push_back(exp_pixel(x, y));
  endtask

  task automatic px_end();
    @(negedge clk);
    px_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic probe(input int i);
    logic [9:0] bx, by;
    logic [3:0] c;
    bx = ms[i].x;
    by = ms[i].y;
    c  = 4'd4 + {2'b00, ms[i].spr};
    px(bx + {6'd0, c}, by + 10'd3);
    px(bx, by);
    px(bx + 10'd15, by + 10'd15);
    px(bx + 10'd16, by);
    px(bx, by + 10'd16);
    px(bx - 10'd1, by + 10'd2);
    px_end();
  endtask

  always @(posedge clk) begin
    v1 <= reset ? 1'b0 : px_valid;
    v2 <= reset ? 1'b0 : v1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      if (sbq.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("pix_on", {31'd0, pix_on}, {31'd0, e.on});
        chk("pix_coin", {31'd0, pix_coin}, {31'd0, e.coin});
        if (e.hit) chk("pix_slot", {30'd0, pix_slot}, {30'd0, e.slot});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset = 1'b1; frame_tick = 1'b0; px_valid = 1'b0; kill_valid = 1'b0;
    px_x = '0; px_y = '0; kill_slot = '0;
    model_reset();
    do_reset();

    @(negedge clk);
    chk("rst_active", {28'd0, active}, 32'd0);
    chk("rst_pix_on", {31'd0, pix_on}, 32'd0);
    chk("rst_pix_coin", {31'd0, pix_coin}, 32'd0);
    chk("rst_pix_slot", {30'd0, pix_slot}, 32'd0);
    chk("rst_rom_y", {28'd0, rom_y}, 32'd0);
    chk("rst_rom_sprite", {30'd0, rom_sprite}, 32'd0);

    // First spawn lands on the 32nd tick; the second 32 ticks later.
    repeat (32) tick(1'b0, 2'd0);
    chk("first_spawn_mask", {28'd0, active}, 32'd1);
    probe(0);
    repeat (32) tick(1'b0, 2'd0);
    chk("second_spawn_mask", {28'd0, active}, 32'd3);
    probe(0);
    probe(1);

    // Kill together with a move: slot 0 cleared, slot 1 still falls.
    tick(1'b1, 2'd0);
    probe(0);
    probe(1);

    // Kill aimed at the inactive spawn target is ignored.
    k = 0;
    while (mcnt != 0 && k < 64) begin
      tick(1'b0, 2'd0);
      k++;
    end
    tick(1'b1, 2'd0);
    chk("spawn_beats_kill", {31'd0, active[0]}, 32'd1);
    probe(0);
    kill_only(2'd1);

    // Long run: fill all slots, drop spawns while full, bottom exit at y=480, respawn.
    for (int t = 0; t < 300; t++) begin
      tick(1'b0, 2'd0);
      if (t % 50 == 49)
        for (int i = 0; i < 4; i++) probe(i);
    end

    // Reset while a pixel is in flight forces pix_on low on the next edge.
    k = 0;
    for (int i = 3; i >= 0; i--) if (ms[i].act) k = i;
    @(negedge clk);
    px_valid = 1'b1;
    px_x     = ms[k].x + {8'd0, 2'd0} + 10'd4 + {8'd0, ms[k].spr};
    px_y     = ms[k].y + 10'd3;
    @(negedge clk);
    px_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("rst_flush_pix_on", {31'd0, pix_on}, 32'd0);
    chk("rst_flush_pix_coin", {31'd0, pix_coin}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_active", {28'd0, active}, 32'd0);
    px(10'd50, 10'd50);
    px_end();

    chk("sb_drain", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/meteor_ctrl.md
METEOR_CTRL -- requirements
Module: meteor_ctrl

Interface
REQ-001 SHALL have parameter N_SLOTS, default 4, number of concurrent meteor slots.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 32, frames between spawn attempts.
REQ-003 SHALL have parameter SPEED, default 2, pixels moved down per frame.
REQ-004 SHALL have ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, during blanking.
- px_valid  in  1  pixel coordinate valid.
- px_x  in  10  current pixel column.
- px_y  in  10  current pixel row.
- kill_valid  in  1  remove a meteor.
- kill_slot  in  2  slot to remove.
- rom_y  out  4  sprite row to ROM.
- rom_sprite  out  2  sprite select to ROM.
- rom_bits  in  16  combinational ROM row, MSB = leftmost pixel.
- pix_on  out  1  meteor pixel lit.
- pix_coin  out  1  lit pixel belongs to sprite 3.
- pix_slot  out  2  slot owning lit pixel.
- active  out  N_SLOTS  slot-occupied mask.

Function
REQ-005 SHALL hold per slot: active bit, x[9:0], y[9:0], sprite[1:0].
REQ-006 SHALL run a 16-bit maximal LFSR (taps 16,14,13,11), advancing every clk; reset seed 16'hACE1.
REQ-007 SHALL decrement a spawn counter on each frame_tick; at zero, reload SPAWN_PERIOD-1 and spawn.
REQ-008 Spawn SHALL fill the lowest-index inactive slot: y=0, x=lfsr[9:0] (minus 512 if >=624), sprite=lfsr[11:10]; all slots full -> spawn dropped, counter still reloads.
REQ-009 On frame_tick each active slot SHALL get y+=SPEED; new y>=480 -> slot inactive same cycle.
REQ-010 Slot spawned on a frame_tick SHALL NOT move on that same tick.
REQ-011 kill_valid SHALL clear active[kill_slot] next cycle; kill beats move on the same slot.
REQ-012 Spawn target SHALL be chosen from the start-of-cycle mask; a kill naming that inactive target has no effect.
REQ-013 Hit test: slot hits when active and unsigned (px_x-x)<16 and (px_y-y)<16 (10-bit); lowest index wins.
REQ-014 Stage 1, registered: rom_y=(px_y-y)[3:0], rom_sprite, col=(px_x-x)[3:0], hit flag, slot; no hit or !px_valid -> hit flag 0.
REQ-015 Stage 2, registered: pix_on = hit_q & rom_bits[15-col_q]; pix_coin = pix_on & (sprite_q==3); pix_slot = slot_q.
REQ-016 Latency px_valid -> pix_on SHALL be exactly 2 cycles, one pixel per cycle, no stalls.
REQ-017 Slot updates on frame_tick SHALL affect hit tests from the next cycle only.

Reset
REQ-018 reset SHALL clear all slots, active=0, rom_y=0, rom_sprite=0, pix_on=0, pix_coin=0, pix_slot=0, pipeline flags=0, and spawn counter=SPAWN_PERIOD-1.
REQ-019 reset mid-frame SHALL force pix_on=0 on the next cycle regardless of in-flight pixels.

Configuration
REQ-020 With METEOR_COIN_EN defined, sprite 3 (coin) SHALL be spawnable and pix_coin functional.
REQ-021 Without METEOR_COIN_EN, lfsr sprite value 3 SHALL map to 0 and pix_coin SHALL be tied 0.

Structure
REQ-022 Package meteor_pkg SHALL hold N_SLOTS, SPAWN_PERIOD, SPEED, SCREEN_W=640, SCREEN_H=480, SPR_SIZE=16, and slot_t struct (active, x, y, sprite).
REQ-023 LFSR SHALL be sub-module lfsr16; the sprite ROM is instantiated outside, connected by rom_y/rom_sprite/rom_bits.

Verification
REQ-024 Reset, 32 frame_ticks -> slot 0 active, y=0, x from LFSR sequence; 64 ticks -> slots 0,1 active.
REQ-025 Force slot 0 x=100,y=200,sprite=0; px=(104,203) -> 2 cycles later pix_on=rom_bits[11] of row 3 = 1.
REQ-026 Slot 0 y=478, frame_tick -> active[0]=0 next cycle.
REQ-027 All 4 slots active, spawn due -> no change, counter reloads to 31.
REQ-028 Slots 0,1 overlapping at px (50,50) -> pix_slot=0; kill_slot=0 with frame_tick -> slot 0 cleared, not moved.
REQ-029 Coin enabled, sprite 3 at (300,100), px (305,105) -> pix_on=1, pix_coin=1; macro undefined -> pix_coin=0.
